// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: RV32M funct3 codes and FSM state encoding.
package ex_muldiv_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Radix-2 restoring divider datapath for unsigned magnitudes; one quotient bit per step.
module ex_muldiv_div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]  quot_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  // The dividend is shifted out of quot_reg while quotient bits shift in behind it.
  assign shifted = {rem_reg, quot_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, div_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_reg <= '0;
      rem_reg  <= '0;
      div_reg  <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      quot_reg <= dividend;
      rem_reg  <= '0;
      div_reg  <= divisor;
      cnt_reg  <= '0;
    end else if (step) begin
      rem_reg  <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quot_reg <= {quot_reg[XLEN-2:0], ~diff[XLEN]};
      cnt_reg  <= cnt_reg + CNT_W'(1);
    end
  end

  assign quotient  = quot_reg;
  assign remainder = rem_reg;
  assign last      = (cnt_reg == CNT_W'(XLEN - 1));

endmodule

// File: rtl/ex_muldiv.sv
// RV32M/RV64M multiply/divide execution unit: control FSM, pipelined multiplier,
// divide special cases and sign fix-up, and the register writeback port.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 1,
  parameter int RADDR_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         funct3_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               hold_o,
  output logic               done_o,
  output logic               regs_wen_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]    rd_data_o
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t             state_reg;
  logic [2:0]         funct3_reg;
  logic [XLEN-1:0]    op1_reg;
  logic [XLEN-1:0]    op2_reg;
  logic [XLEN-1:0]    result_reg;
  logic [RADDR_W-1:0] rd_addr_reg;
  logic [1:0]         mul_cnt_reg;

  // Operand extension picked per op so a single 2*XLEN product serves all four multiplies.
  logic              op1_sext;
  logic              op2_sext;
  logic [2*XLEN-1:0] op1_ext;
  logic [2*XLEN-1:0] op2_ext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_sel;
  logic [XLEN-1:0]   mul_out;

  assign op1_sext = op1_reg[XLEN-1] & (funct3_reg != INST_MULHU);
  assign op2_sext = op2_reg[XLEN-1] & ((funct3_reg == INST_MUL) | (funct3_reg == INST_MULH));
  assign op1_ext  = {{XLEN{op1_sext}}, op1_reg};
  assign op2_ext  = {{XLEN{op2_sext}}, op2_reg};
  assign product  = op1_ext * op2_ext;
  assign mul_sel  = (funct3_reg == INST_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Stage 0 is the raw product; result_reg supplies the final register stage.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_STAGES; gi++) begin : g_mul_stage
      logic [XLEN-1:0] data;
      if (gi == 0) begin : g_head
        assign data = mul_sel;
      end else begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
          if (rst) data <= '0;
          else     data <= g_mul_stage[gi-1].data;
        end
      end
    end
  endgenerate

  assign mul_out = g_mul_stage[MUL_STAGES-1].data;

  logic            div_signed;
  logic            op1_neg;
  logic            op2_neg;
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] op1_abs;
  logic [XLEN-1:0] op2_abs;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic            div_last;

  assign div_signed  = ~funct3_reg[0];
  assign op1_neg     = div_signed & op1_reg[XLEN-1];
  assign op2_neg     = div_signed & op2_reg[XLEN-1];
  assign op1_abs     = op1_neg ? -op1_reg : op1_reg;
  assign op2_abs     = op2_neg ? -op2_reg : op2_reg;
  assign div_by_zero = (op2_reg == '0);
  assign div_ovf     = div_signed & (op1_reg == MIN_NEG) & (&op2_reg);
  assign q_fix       = (op1_neg ^ op2_neg) ? -quotient : quotient;
  assign r_fix       = op1_neg ? -remainder : remainder;

  ex_muldiv_div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (state_reg == ST_DIV_PREP),
    .step      (state_reg == ST_DIV_ITER),
    .dividend  (op1_abs),
    .divisor   (op2_abs),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (div_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      funct3_reg  <= '0;
      op1_reg     <= '0;
      op2_reg     <= '0;
      rd_addr_reg <= '0;
      result_reg  <= '0;
      mul_cnt_reg <= '0;
    end else if (flush_i) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            funct3_reg  <= funct3_i;
            op1_reg     <= op1_i;
            op2_reg     <= op2_i;
            rd_addr_reg <= rd_addr_i;
            mul_cnt_reg <= 2'(MUL_STAGES - 1);
            state_reg   <= funct3_i[2] ? ST_DIV_PREP : ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_cnt_reg == 2'd0) begin
            result_reg <= mul_out;
            state_reg  <= ST_DONE;
          end else begin
            mul_cnt_reg <= mul_cnt_reg - 2'd1;
          end
        end
        ST_DIV_PREP: begin
          if (div_by_zero) begin
            result_reg <= funct3_reg[1] ? op1_reg : '1;
            state_reg  <= ST_DONE;
          end else if (div_ovf) begin
            result_reg <= funct3_reg[1] ? '0 : op1_reg;
            state_reg  <= ST_DONE;
          end else begin
            state_reg <= ST_DIV_ITER;
          end
        end
        ST_DIV_ITER: begin
          if (div_last) state_reg <= ST_DIV_FIX;
        end
        ST_DIV_FIX: begin
          result_reg <= funct3_reg[1] ? r_fix : q_fix;
          state_reg  <= ST_DONE;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // A flush arriving in the DONE cycle still has to cancel the writeback.
  assign busy_o     = (state_reg != ST_IDLE);
  assign done_o     = (state_reg == ST_DONE) & ~flush_i;
  assign regs_wen_o = done_o;
  assign rd_addr_o  = rd_addr_reg;
  assign rd_data_o  = done_o ? result_reg : '0;
  assign hold_o     = (start_i & ~busy_o) | (busy_o & ~done_o);

endmodule
